// File: rtl/hazard_stall_controller.sv
// Front-end hazard/stall controller living in ID. Produces PC hold, IF/ID hold
// and flush, and ID/EX bubble controls for load-use hazards, taken branches and
// a counted freeze while a multi-cycle mul/div occupies EX. Also keeps a
// saturating count of cycles in which the PC was held.
module hazard_stall_controller #(
    parameter int MD_CYCLES = 4,   // freeze cycles after a mul/div issues, 1..15
    parameter int CNT_W     = 4,   // freeze down-counter width
    parameter int STALL_W   = 32   // implemented stall-counter width, 1..32
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [4:0]  ID_Rs,
    input  logic [4:0]  ID_Rt,
    input  logic        ID_UsesRs,
    input  logic        ID_UsesRt,
    input  logic        IDEX_MemRead,
    input  logic [4:0]  IDEX_Rt,
    input  logic        BranchTaken,
    input  logic        ID_MultiCycle,
    output logic        PC_writeOff,
    output logic        IFID_writeOff,
    output logic        IFID_flush,
    output logic        IDEX_bubble,
    output logic        Busy,
    output logic [31:0] StallCount
);

    typedef enum logic {
        RUN = 1'b0,
        MD  = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] MD_LOAD = CNT_W'(MD_CYCLES);

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   md_cnt, md_cnt_nxt;
    logic [STALL_W-1:0] stall_cnt;
    logic               load_use;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [STALL_W-1:0] sat_inc(input logic [STALL_W-1:0] v);
        return (v == '1) ? v : v + STALL_W'(1);
    endfunction

    // A load in EX whose destination (never r0) is read by the instruction in ID.
    assign load_use = IDEX_MemRead && (IDEX_Rt != 5'd0) &&
                      ((ID_UsesRs && (ID_Rs == IDEX_Rt)) ||
                       (ID_UsesRt && (ID_Rt == IDEX_Rt)));

    // Busy is a straight decode of the one-bit state register.
    assign Busy       = (state == MD);
    assign StallCount = 32'(stall_cnt);

    // Next-state and control decode; hazard outranks branch outranks mul/div issue.
    always_comb begin
        state_nxt     = state;
        md_cnt_nxt    = md_cnt;
        PC_writeOff   = 1'b0;
        IFID_writeOff = 1'b0;
        IFID_flush    = 1'b0;
        IDEX_bubble   = 1'b0;
        case (state)
            RUN: begin
                if (load_use) begin
                    PC_writeOff   = 1'b1;
                    IFID_writeOff = 1'b1;
                    IDEX_bubble   = 1'b1;
                end else if (BranchTaken) begin
                    IFID_flush = 1'b1;
                end else if (ID_MultiCycle) begin
                    state_nxt  = MD;
                    md_cnt_nxt = MD_LOAD;
                end
            end
            MD: begin
                PC_writeOff   = 1'b1;
                IFID_writeOff = 1'b1;
                IDEX_bubble   = 1'b1;
                md_cnt_nxt    = md_cnt - CNT_W'(1);
                if (md_cnt == CNT_W'(1)) begin
                    state_nxt = RUN;
                end
            end
            default: begin
                state_nxt  = RUN;
                md_cnt_nxt = '0;
            end
        endcase
    end

    // State and freeze counter; reset drops any freeze in progress at once.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state  <= RUN;
            md_cnt <= '0;
        end else begin
            state  <= state_nxt;
            md_cnt <= md_cnt_nxt;
        end
    end

    // Performance counter of PC-hold cycles.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            stall_cnt <= '0;
        end else if (PC_writeOff) begin
            stall_cnt <= sat_inc(stall_cnt);
        end
    end

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Directed bench for hazard_stall_controller. A cycle-level model tracks
// "freeze cycles remaining" and the expected stall count; every falling edge
// the DUT is compared against it, and directed literal checks pin the model.
module tb_hazard_stall_controller;

    localparam int MD_CYCLES = 4;
    localparam int STALL_W   = 6;
    localparam int SAT       = (1 << STALL_W) - 1;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic [4:0]  ID_Rs = '0, ID_Rt = '0, IDEX_Rt = '0;
    logic        ID_UsesRs = 1'b0, ID_UsesRt = 1'b0, IDEX_MemRead = 1'b0;
    logic        BranchTaken = 1'b0, ID_MultiCycle = 1'b0;
    logic        PC_writeOff, IFID_writeOff, IFID_flush, IDEX_bubble, Busy;
    logic [31:0] StallCount;

    int n_chk = 0;
    int n_err = 0;

    hazard_stall_controller #(
        .MD_CYCLES(MD_CYCLES),
        .CNT_W    (4),
        .STALL_W  (STALL_W)
    ) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .ID_Rs        (ID_Rs),
        .ID_Rt        (ID_Rt),
        .ID_UsesRs    (ID_UsesRs),
        .ID_UsesRt    (ID_UsesRt),
        .IDEX_MemRead (IDEX_MemRead),
        .IDEX_Rt      (IDEX_Rt),
        .BranchTaken  (BranchTaken),
        .ID_MultiCycle(ID_MultiCycle),
        .PC_writeOff  (PC_writeOff),
        .IFID_writeOff(IFID_writeOff),
        .IFID_flush   (IFID_flush),
        .IDEX_bubble  (IDEX_bubble),
        .Busy         (Busy),
        .StallCount   (StallCount)
    );

    always #5 Clk = ~Clk;

    // ---------------- model ----------------
    int   m_left = 0;   // freeze cycles still to run
    int   m_cnt  = 0;   // expected stall count
    logic m_hz;
    logic [4:0] m_exp;  // {pc_off, ifid_off, flush, bubble, busy}

    always_comb begin
        m_hz = IDEX_MemRead && (IDEX_Rt != 0) &&
               ((ID_UsesRs && ID_Rs == IDEX_Rt) || (ID_UsesRt && ID_Rt == IDEX_Rt));
        if (m_left > 0)       m_exp = 5'b11011;
        else if (m_hz)        m_exp = 5'b11010;
        else if (BranchTaken) m_exp = 5'b00100;
        else                  m_exp = 5'b00000;
    end

    always @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            m_left <= 0;
            m_cnt  <= 0;
        end else begin
            if (m_exp[4] && m_cnt < SAT) m_cnt <= m_cnt + 1;
            if (m_left > 0)                                 m_left <= m_left - 1;
            else if (!m_hz && !BranchTaken && ID_MultiCycle) m_left <= MD_CYCLES;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge Clk) begin
        if (!Reset) begin
            chk("model_ctl", 32'({PC_writeOff, IFID_writeOff, IFID_flush, IDEX_bubble, Busy}),
                32'(m_exp));
            chk("model_cnt", StallCount, 32'(m_cnt));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic drive(input logic mr, input logic [4:0] xrt, input logic [4:0] rs,
                         input logic urs, input logic [4:0] rt, input logic urt,
                         input logic br, input logic mc);
        IDEX_MemRead = mr; IDEX_Rt = xrt; ID_Rs = rs; ID_UsesRs = urs;
        ID_Rt = rt; ID_UsesRt = urt; BranchTaken = br; ID_MultiCycle = mc;
        #2;
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic ctl(input string name, input logic [4:0] exp);
        chk(name, 32'({PC_writeOff, IFID_writeOff, IFID_flush, IDEX_bubble, Busy}), 32'(exp));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        tick(); tick();
        ctl("reset_ctl", 5'b00000);
        chk("reset_cnt", StallCount, 32'd0);
        Reset = 1'b0;

        // load-use on rs
        tick();
        drive(1, 5, 5, 1, 0, 0, 0, 0);
        ctl("lu_rs", 5'b11010);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        ctl("lu_one_cycle", 5'b00000);
        chk("lu_cnt", StallCount, 32'd1);
        // destination r0 never stalls
        drive(1, 0, 0, 1, 0, 1, 0, 0);
        ctl("lu_r0", 5'b00000);
        tick();
        // load-use on rt, then same regs without the rt read
        drive(1, 7, 3, 1, 7, 1, 0, 0);
        ctl("lu_rt", 5'b11010);
        tick();
        drive(1, 7, 3, 1, 7, 0, 0, 0);
        ctl("lu_rt_unused", 5'b00000);
        chk("lu_cnt2", StallCount, 32'd2);
        tick();

        // taken branch
        drive(0, 0, 0, 0, 0, 0, 1, 0);
        ctl("branch", 5'b00100);
        tick();
        // hazard beats branch, then branch alone
        drive(1, 9, 9, 1, 0, 0, 1, 0);
        ctl("prio_hz", 5'b11010);
        tick();
        drive(0, 9, 9, 1, 0, 0, 1, 0);
        ctl("prio_br", 5'b00100);
        chk("prio_cnt", StallCount, 32'd3);
        tick();

        // multi-cycle: issue, then 4 frozen cycles ignoring inputs
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        ctl("md_issue", 5'b00000);
        tick();
        for (int i = 1; i <= MD_CYCLES; i++) begin
            drive(1, 4, 4, 1, 0, 0, 1, 1);
            ctl("md_freeze", 5'b11011);
            tick();
        end
        // back-to-back mul/div issues on the first RUN cycle
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        ctl("md_run_again", 5'b00000);
        chk("md_cnt", StallCount, 32'd7);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        ctl("md_reenter", 5'b11011);
        tick(); tick();
        // third freeze cycle (counter at 2): asynchronous reset mid-freeze
        chk("pre_reset_cnt", StallCount, 32'd9);
        #1 Reset = 1'b1;
        #1;
        ctl("async_reset_ctl", 5'b00000);
        chk("async_reset_cnt", StallCount, 32'd0);
        #1 Reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            ctl("post_reset_idle", 5'b00000);
        end

        // saturation: continuous mul/div stream, 4 stalls per 5 cycles
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 100; i++) tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) tick();
        chk("sat_cnt", StallCount, 32'(SAT));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/hazard_stall_controller.md
# hazard_stall_controller

Front-end pipeline controller that generates the stall, flush and bubble controls for the PC register, the IF/ID pipeline register and the ID/EX pipeline register. It sits in the ID stage.

- It detects load-use hazards.
- It flushes the IF/ID register on taken branches resolved in ID.
- It sequences a counted front-end freeze while a multi-cycle multiply/divide occupies EX.
- It keeps a saturating stall-cycle performance counter.

## Interface

Parameters:
- MD_CYCLES, 4, number of freeze cycles after a multi-cycle op issues; legal range 1..15.
- CNT_W, 4, width of the freeze down-counter.

Ports:
- Clk  input  1  clock; all state updates on rising edge.
- Reset  input  1  asynchronous, active-high reset.
- ID_Rs  input  5  rs field of the instruction in ID.
- ID_Rt  input  5  rt field of the instruction in ID.
- ID_UsesRs  input  1  ID instruction reads rs.
- ID_UsesRt  input  1  ID instruction reads rt.
- IDEX_MemRead  input  1  instruction in EX is a load.
- IDEX_Rt  input  5  destination register of the load in EX.
- BranchTaken  input  1  branch in ID resolved taken this cycle.
- ID_MultiCycle  input  1  instruction in ID is a mul/div.
- PC_writeOff  output  1  hold PC.
- IFID_writeOff  output  1  hold IF/ID (register replays its saved contents).
- IFID_flush  output  1  load a NOP into IF/ID.
- IDEX_bubble  output  1  zero the ID/EX control fields.
- Busy  output  1  multi-cycle freeze in progress.
- StallCount  output  32  cycles with PC_writeOff=1; saturates at 32'hFFFFFFFF.

## Operation

- Two FSM states: RUN and MD.
- Output decode:
  - Outputs are combinational from the current state and inputs.
  - StallCount and Busy come straight from registers.
- Load-use hazard (RUN only), raised when all of the following hold:
  - IDEX_MemRead=1;
  - IDEX_Rt != 0;
  - either (ID_UsesRs and ID_Rs==IDEX_Rt) or (ID_UsesRt and ID_Rt==IDEX_Rt).
- RUN priority, highest first:
  1. Load-use hazard: PC_writeOff=1, IFID_writeOff=1, IDEX_bubble=1. BranchTaken and ID_MultiCycle are ignored this cycle; the held instruction re-evaluates next cycle.
  2. BranchTaken=1: IFID_flush=1; all other controls 0. ID_MultiCycle is ignored; the branch itself is never multi-cycle.
  3. ID_MultiCycle=1: all controls 0, so the op issues to EX. At the edge, go to MD and load the counter with MD_CYCLES.
  4. Otherwise all controls 0.
- MD state:
  - Outputs: PC_writeOff=1, IFID_writeOff=1, IDEX_bubble=1, IFID_flush=0, Busy=1.
  - All hazard/branch/multi-cycle inputs are ignored.
  - The counter decrements each edge. On the edge where counter==1, return to RUN.
- IFID_writeOff and IFID_flush are never asserted together; the IF/ID register gives writeOff precedence.
- StallCount increments by 1 on every edge where PC_writeOff=1, and holds at all-ones.

## Timing

- Reset, asserted at any time including mid-freeze, takes effect immediately:
  - state=RUN, counter=0, StallCount=0, Busy=0;
  - all control outputs evaluate to 0, given no RUN hazard on the inputs.
- Load-use: zero-latency (same-cycle) assertion, lasting exactly 1 cycle for a single load. By then the load has moved to MEM and forwarding covers it.
- Branch flush: same-cycle, 1 cycle per taken branch.
- Multi-cycle sequence:
  - Issue cycle (cycle 0) has no stall.
  - Cycles 1..MD_CYCLES each assert stall and bubble.
  - Cycle MD_CYCLES+1 is RUN again with normal evaluation.
- MD_CYCLES=1 gives exactly one freeze cycle.
- Back-to-back: a mul/div held in IF/ID during MD evaluates normally on the first RUN cycle and may immediately re-enter MD.
- Reset deasserted mid-program resumes from RUN; no partial freeze remains.

## Test plan

- Reset: pulse Reset asynchronously while in MD with counter=2 → Busy=0 and all controls 0 immediately, StallCount=0; then with inputs idle there is no stall for 5 cycles.
- Load-use: IDEX_MemRead=1, IDEX_Rt=5, ID_Rs=5, ID_UsesRs=1 for one cycle → PC_writeOff=IFID_writeOff=IDEX_bubble=1 that cycle only; StallCount 0→1. Repeat with IDEX_Rt=0 → no stall.
- Branch: BranchTaken=1 for one cycle, no hazard → IFID_flush=1 and IFID_writeOff=0 that cycle; StallCount unchanged.
- Priority: load-use condition and BranchTaken=1 in the same cycle → stall asserted, IFID_flush=0. Next cycle, with the hazard cleared and BranchTaken=1 → flush only.
- Multi-cycle, MD_CYCLES=4: ID_MultiCycle=1 at cycle 0 → no stall at cycle 0; Busy and stall at cycles 1–4 regardless of BranchTaken/hazard inputs; RUN at cycle 5; StallCount=4.
- Saturation: force StallCount near all-ones via a long MD sequence, or a bench with reduced counter width → count holds at all-ones and never wraps.
